// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the two-port memory access arbiter.
// Op encoding matches the control unit's MemReadWrite pin.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic port_t;

    localparam port_t PORT_CPU = 1'b0;
    localparam port_t PORT_LDR = 1'b1;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    function automatic logic [1:0] port_onehot(input port_t p);
        return (p == PORT_LDR) ? 2'b10 : 2'b01;
    endfunction

    function automatic port_t onehot_port(input logic [1:0] oh);
        return oh[1] ? PORT_LDR : PORT_CPU;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_rr_pick2.sv
// Two-way round-robin winner select; purely combinational, one-hot result.
// On contention the port that did not own the previous transaction wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last_grant,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        if (req == 2'b11) begin
            win = port_onehot(~last_grant);
        end else if (req[PORT_CPU]) begin
            win = port_onehot(PORT_CPU);
        end else if (req[PORT_LDR]) begin
            win = port_onehot(PORT_LDR);
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the single-port memory between the CPU (port 0) and the loader (port 1)
// with a req/done handshake and a parameterised access latency.
//
// state  | meaning
// IDLE   | arbitrate pending requests, latch the winner's op/addr/wdata
// ACCESS | memory pins driven from latched values, latency counter running
// DONE   | one-cycle done pulse to the owner, last-grant updated
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int READ_LAT  = 3,
    parameter int WRITE_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    // Counter reaches zero on the last ACCESS cycle, so ACCESS lasts exactly LAT cycles.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

    state_t           state;
    port_t            last_grant;
    logic             op_we;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       win;
    port_t            win_port;

    rr_pick2 u_pick (
        .req        (req),
        .last_grant (last_grant),
        .win        (win)
    );

    assign win_port = onehot_port(win);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= PORT_LDR;
            op_we      <= MEM_READ;
            cnt        <= '0;
            gnt        <= 2'b00;
            done       <= 2'b00;
            busy       <= 1'b0;
            mem_rw     <= MEM_READ;
            rdata      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win != 2'b00) begin
                        state     <= ACCESS;
                        gnt       <= win;
                        busy      <= 1'b1;
                        op_we     <= we[win_port];
                        mem_rw    <= we[win_port];
                        mem_addr  <= (win_port == PORT_LDR) ? addr1 : addr0;
                        mem_wdata <= (win_port == PORT_LDR) ? wdata1 : wdata0;
                        cnt       <= (we[win_port] == MEM_WRITE) ? WR_LOAD : RD_LOAD;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (op_we == MEM_READ) begin
                            rdata <= mem_rdata;
                        end
                        mem_rw <= MEM_READ;
                        done   <= gnt;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done       <= 2'b00;
                    gnt        <= 2'b00;
                    busy       <= 1'b0;
                    last_grant <= onehot_port(gnt);
                    state      <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    gnt    <= 2'b00;
                    done   <= 2'b00;
                    busy   <= 1'b0;
                    mem_rw <= MEM_READ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomised scoreboard bench for mem_access_arbiter over three latency configurations,
// including a reset that aborts a transaction mid-access.
module tb_mem_access_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int fin    = 0;

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          done_cyc;
    } exp_t;

    task automatic check(input bit ok, input string name, input int cfg_id,
                         input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0h want %0h (cycle %0d)", cfg_id, name, act, want, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (32'h9E37_79B9 * 32'(i)) ^ 32'hC0DE_0000;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int RL = (g == 0) ? 3 : (g == 1) ? 1 : 2;
        localparam int WL = (g == 0) ? 1 : (g == 1) ? 2 : 3;

        logic        reset  = 1'b0;
        logic [1:0]  req    = 2'b00;
        logic [1:0]  we     = 2'b00;
        logic [31:0] addr0  = '0;
        logic [31:0] addr1  = '0;
        logic [31:0] wdata0 = '0;
        logic [31:0] wdata1 = '0;
        logic [31:0] mem_rdata;
        logic [1:0]  gnt, done;
        logic [31:0] rdata, mem_addr, mem_wdata;
        logic        busy, mem_rw;

        // memory side: data is only valid once the address has been held RL cycles
        logic [31:0] mem [64];
        int          age = 0;
        assign mem_rdata = (age == RL) ? mem[mem_addr[7:2]] : (32'hBAD0_0000 | 32'(age));

        // reference model state
        exp_t        q[$];
        int          free_at = 1 << 30;
        bit          last = 1'b1;
        logic [31:0] last_rd = '0;
        logic [31:0] mmem [64];
        bit          inflight [2];
        int          done_at [2];

        mem_access_arbiter #(
            .ADDR_W    (32),
            .DATA_W    (32),
            .READ_LAT  (RL),
            .WRITE_LAT (WL)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .req       (req),
            .we        (we),
            .addr0     (addr0),
            .addr1     (addr1),
            .wdata0    (wdata0),
            .wdata1    (wdata1),
            .gnt       (gnt),
            .done      (done),
            .rdata     (rdata),
            .busy      (busy),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rw    (mem_rw),
            .mem_rdata (mem_rdata)
        );

        task automatic new_txn(input int p, input bit force_read);
            logic [31:0] a, d;
            bit          w;
            a = 32'($urandom_range(0, 63)) << 2;
            d = $urandom;
            w = force_read ? 1'b0 : 1'($urandom_range(0, 1));
            req[p] = 1'b1;
            we[p]  = w;
            if (p == 0) begin addr0 = a; wdata0 = d; end
            else        begin addr1 = a; wdata1 = d; end
        endtask

        // transaction-level arbiter: free after done+1, alternation on contention
        task automatic arbitrate();
            int   w, lat;
            exp_t e;
            if (cyc >= free_at && req != 2'b00) begin
                if (req == 2'b11) w = last ? 0 : 1;
                else              w = req[1] ? 1 : 0;
                e.port  = w;
                e.we    = we[w];
                e.addr  = (w == 1) ? addr1 : addr0;
                e.wdata = (w == 1) ? wdata1 : wdata0;
                if (e.we) mmem[e.addr[7:2]] = e.wdata;
                else      last_rd = mmem[e.addr[7:2]];
                e.rdata    = last_rd;
                lat        = e.we ? WL : RL;
                e.done_cyc = cyc + lat + 1;
                free_at    = e.done_cyc + 1;
                last       = (w == 1);
                inflight[w] = 1'b1;
                done_at[w]  = e.done_cyc;
                q.push_back(e);
            end
        endtask

        task automatic step(input bit allow_new);
            for (int p = 0; p < 2; p++) begin
                if (inflight[p] && cyc == done_at[p]) begin
                    inflight[p] = 1'b0;
                    if (allow_new && $urandom_range(0, 1) == 1) new_txn(p, 1'b0);
                    else req[p] = 1'b0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (allow_new && !req[p] && !inflight[p] && $urandom_range(0, 3) == 0) begin
                    new_txn(p, 1'b0);
                end else if (inflight[p]) begin
                    req[p] = 1'($urandom_range(0, 1));
                    we[p]  = 1'($urandom_range(0, 1));
                    if (p == 0) begin addr0 = $urandom; wdata0 = $urandom; end
                    else        begin addr1 = $urandom; wdata1 = $urandom; end
                end
            end
            arbitrate();
        endtask

        initial begin : drv
            int n;
            int t;
            bit use_we;
            for (int i = 0; i < 64; i++) mmem[i] = init_word(i);
            repeat (3) @(negedge clock);
            check(gnt == 2'b00, "rst_gnt", g, gnt, 0);
            check(done == 2'b00, "rst_done", g, done, 0);
            check(busy == 1'b0 && mem_rw == 1'b0, "rst_busy_rw", g, {busy, mem_rw}, 0);
            check(rdata == '0, "rst_rdata", g, rdata, 0);
            check(mem_addr == '0 && mem_wdata == '0, "rst_mem_pins", g, {mem_addr, mem_wdata}, 0);

            reset   = 1'b1;
            free_at = cyc;
            repeat (400) begin
                step(1'b1);
                @(negedge clock);
            end
            n = 0;
            while ((req != 2'b00 || inflight[0] || inflight[1] || cyc < free_at) && n < 200) begin
                @(negedge clock);
                step(1'b0);
                n++;
            end
            check(n < 200, "drain_timeout", g, n, 200);

            // reset in the second ACCESS cycle of a transaction at least two cycles long
            @(negedge clock);
            use_we = (WL >= 2);
            req    = 2'b10;
            we     = {use_we, 1'b0};
            addr1  = 32'h0000_0080;
            wdata1 = 32'h1234_5678;
            arbitrate();
            t = cyc;
            @(negedge clock);
            check(gnt == 2'b10, "abort_gnt_acc", g, gnt, 2'b10);
            check(mem_rw == use_we, "abort_rw_acc", g, mem_rw, use_we);
            check(mem_addr == 32'h80, "abort_addr", g, mem_addr, 32'h80);
            @(negedge clock);
            reset = 1'b0;
            @(negedge clock);
            check(cyc == t + 3, "abort_timing", g, cyc, t + 3);
            check(mem_rw == 1'b0, "abort_rw", g, mem_rw, 0);
            check(gnt == 2'b00, "abort_gnt", g, gnt, 0);
            check(busy == 1'b0, "abort_busy", g, busy, 0);
            check(done == 2'b00, "abort_done", g, done, 0);
            q.delete();
            inflight[0] = 1'b0;
            inflight[1] = 1'b0;
            req     = 2'b00;
            last    = 1'b1;
            last_rd = '0;
            free_at = 1 << 30;
            repeat (2) @(negedge clock);
            check(rdata == '0, "abort_rdata", g, rdata, 0);

            reset   = 1'b1;
            free_at = cyc;
            new_txn(0, 1'b1);
            new_txn(1, 1'b1);
            arbitrate();
            n = 0;
            while ((req != 2'b00 || inflight[0] || inflight[1] || cyc < free_at) && n < 200) begin
                @(negedge clock);
                step(1'b0);
                n++;
            end
            check(n < 200, "drain2_timeout", g, n, 200);
            repeat (3) @(negedge clock);
            check(q.size() == 0, "missing_done", g, q.size(), 0);
            fin++;
        end

        initial begin : mon
            int   wr_cycles;
            exp_t e;
            wr_cycles = 0;
            for (int i = 0; i < 64; i++) mem[i] = init_word(i);
            forever begin
                @(posedge clock);
                #1;
                age = (gnt != 2'b00 && done == 2'b00) ? age + 1 : 0;
                check($onehot0(gnt) && (busy == (gnt != 2'b00)) && !(mem_rw && (!busy || done != 2'b00)),
                      "invariant", g, {gnt, done, busy, mem_rw}, 0);
                if (!busy) wr_cycles = 0;
                if (mem_rw) begin
                    wr_cycles++;
                    mem[mem_addr[7:2]] = mem_wdata;
                    if (q.size() == 0) begin
                        check(1'b0, "rw_without_txn", g, mem_addr, 0);
                    end else begin
                        check(q[0].we, "rw_on_read", g, mem_rw, q[0].we);
                        check(mem_addr == q[0].addr, "wr_addr", g, mem_addr, q[0].addr);
                        check(mem_wdata == q[0].wdata, "wr_data", g, mem_wdata, q[0].wdata);
                    end
                end
                if (done != 2'b00) begin
                    if (q.size() == 0) begin
                        check(1'b0, "unexpected_done", g, done, 0);
                    end else begin
                        e = q.pop_front();
                        check(done == ((e.port == 1) ? 2'b10 : 2'b01), "done_port", g, done,
                              (e.port == 1) ? 2'b10 : 2'b01);
                        check(cyc == e.done_cyc, "done_cycle", g, cyc, e.done_cyc);
                        check(rdata == e.rdata, "rdata", g, rdata, e.rdata);
                        check(mem_addr == e.addr, "done_addr", g, mem_addr, e.addr);
                        check(wr_cycles == (e.we ? WL : 0), "rw_cycles", g, wr_cycles, e.we ? WL : 0);
                        if (e.we) check(mem[e.addr[7:2]] == e.wdata, "mem_written", g,
                                        mem[e.addr[7:2]], e.wdata);
                    end
                end
            end
        end
    end

    initial begin : top_ctl
        int n;
        n = 0;
        while (fin < 3 && n < 20000) begin
            @(posedge clock);
            n++;
        end
        check(fin == 3, "overall_timeout", 9, fin, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
